// File: rtl/objectbuffer_s_axi_regs.sv
// objectbuffer AXI4-Lite register bank: four 32-bit R/W registers (0x0/0x4/0x8/0xC) mirrored live on REG_OUT.
// Latency: BVALID visible one cycle after the final AW/W handshake; RVALID one cycle after the AR handshake.
// Backpressure: one transaction in flight per channel; B/R payloads hold until BREADY/RREADY, readies drop meanwhile.
// Build option OBJBUF_SLVERR_EN: addresses with any bit set above the register index answer SLVERR instead of aliasing.
module objectbuffer_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADDR_LSB           = 2
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT
);

  localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_VALID} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                            armed;
  logic [C_S_AXI_DATA_WIDTH-1:0]   regs [4];

  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]               w_strb_q;
  logic [1:0]                      bresp_q;
  logic [1:0]                      rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;

  logic                            aw_hs, w_hs, ar_hs;
  logic                            commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   commit_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   commit_data;
  logic [STRB_W-1:0]               commit_strb;
  logic [1:0]                      commit_idx, ar_idx;
  logic                            commit_oor, ar_oor;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign commit_idx = commit_addr[ADDR_LSB+1:ADDR_LSB];
  assign ar_idx     = S_AXI_ARADDR[ADDR_LSB+1:ADDR_LSB];

`ifdef OBJBUF_SLVERR_EN
  // Anything above the four-register window is rejected rather than aliased.
  assign commit_oor = (commit_addr  >> (ADDR_LSB + 2)) != '0;
  assign ar_oor     = (S_AXI_ARADDR >> (ADDR_LSB + 2)) != '0;
`else
  assign commit_oor = 1'b0;
  assign ar_oor     = 1'b0;
`endif

  // Protection bits and the byte-offset/upper address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR, commit_addr};

  // Readies are held off for one cycle after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  // Write FSM: readies per state, commit source selection (live vs latched beat), next state.
  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    commit        = 1'b0;
    commit_addr   = aw_addr_q;
    commit_data   = w_data_q;
    commit_strb   = w_strb_q;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = armed;
        S_AXI_WREADY  = armed;
        if (armed && S_AXI_AWVALID && S_AXI_WVALID) begin
          commit      = 1'b1;
          commit_addr = S_AXI_AWADDR;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_state_nxt = W_RESP;
        end else if (armed && S_AXI_AWVALID) begin
          w_state_nxt = W_WAIT_DATA;
        end else if (armed && S_AXI_WVALID) begin
          w_state_nxt = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) begin
          commit      = 1'b1;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_state_nxt = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) begin
          commit      = 1'b1;
          commit_addr = S_AXI_AWADDR;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Hold whichever half of a split write arrives first.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register bank: byte-strobed update on commit; rejected addresses leave it untouched.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit && !commit_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (commit_strb[b]) regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  // Write response code is fixed at commit and held through W_RESP.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)      bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= commit_oor ? RESP_SLVERR : RESP_OKAY;
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  // Read FSM: accept one address, then present data until RREADY.
  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = armed;
        if (armed && S_AXI_ARVALID) r_state_nxt = R_VALID;
      end
      R_VALID: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read data is sampled at the AR handshake, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= ar_oor ? '0 : regs[ar_idx];
      rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign REG_OUT     = {regs[3], regs[2], regs[1], regs[0]};

endmodule

// File: tb/tb_objectbuffer_s_axi_regs.sv
`timescale 1ns/1ps
module tb_objectbuffer_s_axi_regs;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [127:0]  reg_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [4];

  objectbuffer_s_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .ADDR_LSB(2)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_oor(input logic [AW-1:0] a);
`ifdef OBJBUF_SLVERR_EN
    return a >= 8'h10;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return (int'(a) % 16) / 4;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
    return is_oor(a) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [AW-1:0] a);
    return is_oor(a) ? 32'h0 : mdl[word_of(a)];
  endfunction

  function automatic void mdl_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    if (is_oor(a)) return;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    mdl[word_of(a)] = (mdl[word_of(a)] & ~m) | (d & m);
  endfunction

  function automatic logic [127:0] mdl_regout();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
  endfunction

  // ---------------- bus drivers (observe only, no verdicts) ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int bready_dly,
                          output logic [1:0] resp, output bit ok, output bit wait_ok, output bit hold_ok);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] first_resp;
    ok = 1; wait_ok = 1; hold_ok = 1; resp = 2'bxx;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 64) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      if (aw_done && (awready !== 1'b0 || wready !== 1'b1)) wait_ok = 0;
      if (w_done  && (wready  !== 1'b0 || awready !== 1'b1)) wait_ok = 0;
      aw_hs = awvalid && (awready === 1'b1);
      w_hs  = wvalid  && (wready  === 1'b1);
      @(posedge clk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done  || w_hs;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin ok = 0; return; end
    if (bvalid !== 1'b1) ok = 0;
    first_resp = bresp;
    for (int i = 0; i < bready_dly; i++) begin
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || bresp !== first_resp) hold_ok = 0;
      @(posedge clk); #1;
    end
    bready = 1; cyc = 0;
    while (bvalid !== 1'b1 && cyc < 16) begin @(posedge clk); #1; cyc++; end
    if (bvalid !== 1'b1) begin ok = 0; bready = 0; return; end
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
    if (bvalid !== 1'b0) ok = 0;
    mdl_write(a, d, s);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int rready_dly,
                         output logic [31:0] data, output logic [1:0] resp, output bit ok, output bit hold_ok);
    bit hs;
    int cyc;
    ok = 1; hold_ok = 1; hs = 0; cyc = 0; data = 'x; resp = 'x;
    araddr = a; arvalid = 1;
    while (!hs && cyc < 64) begin
      hs = (arready === 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 0;
    if (!hs) begin ok = 0; return; end
    if (rvalid !== 1'b1) ok = 0;
    data = rdata; resp = rresp;
    for (int i = 0; i < rready_dly; i++) begin
      if (rvalid !== 1'b1 || rdata !== data || rresp !== resp || arready !== 1'b0) hold_ok = 0;
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    if (rvalid !== 1'b0) ok = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0 || reg_out !== 128'h0) begin
      errors++; $display("FAIL reset_payload bresp=%h rresp=%h rdata=%h reg_out=%h want all zero", bresp, rresp, rdata, reg_out);
    end
    rst = 0;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_first_cycle_ready got=%b want=000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL reset_armed_ready got=%b want=111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] d; bit ok, wok, hok;
    for (int i = 0; i < 4; i++) begin
      do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, resp, ok, wok, hok);
      checks++;
      if (!ok || resp !== 2'b00) begin
        errors++; $display("FAIL basic_write%0d ok=%0d resp=%b want ok=1 resp=00", i, ok, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(AW'(4 * i), 0, d, resp, ok, hok);
      checks++;
      if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
        errors++; $display("FAIL basic_read%0d ok=%0d data=%h resp=%b want data=%h resp=00", i, ok, d, resp, i + 1);
      end
    end
    checks++;
    if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
      errors++; $display("FAIL basic_reg_out got=%h want=00000004000000030000000200000001", reg_out);
    end
  endtask

  task automatic test_split();
    logic [1:0] resp; logic [31:0] d; bit ok, wok, hok;
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0, resp, ok, wok, hok);
    checks++;
    if (!ok || !wok || resp !== 2'b00) begin
      errors++; $display("FAIL split_aw_first ok=%0d wait_ok=%0d resp=%b want 1 1 00", ok, wok, resp);
    end
    do_write(8'h0C, 32'h5A5A1234, 4'hF, 3, 0, 0, resp, ok, wok, hok);
    checks++;
    if (!ok || !wok || resp !== 2'b00) begin
      errors++; $display("FAIL split_w_first ok=%0d wait_ok=%0d resp=%b want 1 1 00", ok, wok, resp);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL split_single_bvalid bvalid=%b want=0", bvalid);
    end
    do_read(8'h08, 0, d, resp, ok, hok);
    checks++;
    if (!ok || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL split_read8 ok=%0d data=%h want=deadbeef", ok, d);
    end
    checks++;
    if (reg_out !== mdl_regout()) begin
      errors++; $display("FAIL split_reg_out got=%h want=%h", reg_out, mdl_regout());
    end
  endtask

  task automatic test_bresp_hold();
    logic [1:0] resp; bit ok, wok, hok;
    do_write(8'h04, 32'h0BADF00D, 4'hF, 0, 0, 5, resp, ok, wok, hok);
    checks++;
    if (!ok || !hok || resp !== 2'b00) begin
      errors++; $display("FAIL bresp_hold ok=%0d hold_ok=%0d resp=%b want 1 1 00", ok, hok, resp);
    end
    checks++;
    if ({awready, wready} !== 2'b11) begin
      errors++; $display("FAIL bresp_back_to_idle ready=%b want=11", {awready, wready});
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] d; bit ok, wok, hok;
    do_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, ok, wok, hok);
    do_write(8'h00, 32'h12345678, 4'b0010, 0, 0, 0, resp, ok, wok, hok);
    do_read(8'h00, 0, d, resp, ok, hok);
    checks++;
    if (!ok || d !== 32'hFFFF56FF) begin
      errors++; $display("FAIL strobe_byte1 ok=%0d data=%h want=ffff56ff", ok, d);
    end
    do_write(8'h03, 32'h00000000, 4'b0000, 0, 0, 0, resp, ok, wok, hok);
    do_read(8'h02, 2, d, resp, ok, hok);
    checks++;
    if (!ok || !hok || d !== 32'hFFFF56FF || resp !== 2'b00) begin
      errors++; $display("FAIL strobe_zero ok=%0d hold=%0d data=%h resp=%b want ffff56ff 00", ok, hok, d, resp);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] old_v, new_v;
    old_v = mdl[2];
    new_v = old_v ^ 32'hA5A5_0F0F;
    awaddr = 8'h08; wdata = new_v; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_v) begin
      errors++; $display("FAIL concurrent_prewrite rvalid=%b bvalid=%b rdata=%h want 1 1 %h", rvalid, bvalid, rdata, old_v);
    end
    mdl_write(8'h08, new_v, 4'hF);
    checks++;
    if (reg_out !== mdl_regout()) begin
      errors++; $display("FAIL concurrent_reg_out got=%h want=%h", reg_out, mdl_regout());
    end
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
  endtask

  task automatic test_back_to_back();
    int nw, nr, cyc;
    bit w_hs, r_hs, pend;
    logic [31:0] exp_rd;
    nw = 0; nr = 0; pend = 0; exp_rd = 0;
    awaddr = 8'h00; wdata = $urandom; wstrb = 4'hF; araddr = 8'h04;
    awvalid = 1; wvalid = 1; bready = 1; arvalid = 1; rready = 1;
    for (cyc = 0; cyc < 8; cyc++) begin
      w_hs = (awready === 1'b1) && (wready === 1'b1);
      r_hs = (arready === 1'b1);
      if (r_hs) exp_rd = mdl_read(araddr);
      @(posedge clk); #1;
      if (w_hs) begin
        mdl_write(awaddr, wdata, wstrb);
        nw++;
        awaddr = AW'(4 * (nw % 4)); wdata = $urandom;
      end
      if (r_hs) begin
        nr++; pend = 1;
      end
      if (pend && rvalid === 1'b1) begin
        checks++;
        if (rdata !== exp_rd) begin
          errors++; $display("FAIL b2b_read%0d data=%h want=%h", nr, rdata, exp_rd);
        end
        pend = 0;
        araddr = AW'(4 * ((nr + 1) % 4));
      end
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    checks++;
    if (nw != 4 || nr != 4) begin
      errors++; $display("FAIL b2b_throughput writes=%0d reads=%0d want 4 4", nw, nr);
    end
    checks++;
    if (reg_out !== mdl_regout()) begin
      errors++; $display("FAIL b2b_reg_out got=%h want=%h", reg_out, mdl_regout());
    end
  endtask

  task automatic test_alias();
    logic [1:0] resp; logic [31:0] d; bit ok, wok, hok;
    do_write(8'h00, 32'h11111111, 4'hF, 0, 0, 0, resp, ok, wok, hok);
    do_write(8'h10, 32'h00000099, 4'hF, 0, 0, 0, resp, ok, wok, hok);
    checks++;
    if (!ok || resp !== exp_resp(8'h10)) begin
      errors++; $display("FAIL alias_write_resp ok=%0d resp=%b want=%b", ok, resp, exp_resp(8'h10));
    end
    checks++;
    if (reg_out !== mdl_regout()) begin
      errors++; $display("FAIL alias_reg_out got=%h want=%h", reg_out, mdl_regout());
    end
    do_read(8'h10, 1, d, resp, ok, hok);
    checks++;
    if (!ok || d !== mdl_read(8'h10) || resp !== exp_resp(8'h10)) begin
      errors++; $display("FAIL alias_read ok=%0d data=%h resp=%b want %h %b", ok, d, resp, mdl_read(8'h10), exp_resp(8'h10));
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] d, dat; logic [3:0] s; logic [AW-1:0] a; bit ok, wok, hok;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom; s = 4'($urandom);
        do_write(a, dat, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, ok, wok, hok);
        checks++;
        if (!ok || !wok || !hok || resp !== exp_resp(a)) begin
          errors++; $display("FAIL rand_write%0d addr=%h ok=%0d/%0d/%0d resp=%b want=%b", n, a, ok, wok, hok, resp, exp_resp(a));
        end
      end else begin
        do_read(a, $urandom_range(0, 2), d, resp, ok, hok);
        checks++;
        if (!ok || !hok || d !== mdl_read(a) || resp !== exp_resp(a)) begin
          errors++; $display("FAIL rand_read%0d addr=%h ok=%0d/%0d data=%h resp=%b want %h %b", n, a, ok, hok, d, resp, mdl_read(a), exp_resp(a));
        end
      end
    end
    checks++;
    if (reg_out !== mdl_regout()) begin
      errors++; $display("FAIL rand_reg_out got=%h want=%h", reg_out, mdl_regout());
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; bit ok, hok;
    awaddr = 8'h04; wdata = 32'hAA55AA55; wstrb = 4'hF; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    checks++;
    if ({awready, wready} !== 2'b01) begin
      errors++; $display("FAIL mid_wait_data ready=%b want=01", {awready, wready});
    end
    rst = 1;
    #1;
    mdl_clear();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'h0 || rdata !== 32'h0 || reg_out !== 128'h0) begin
      errors++; $display("FAIL mid_reset_outputs hs=%b bresp=%b rresp=%b rdata=%h reg_out=%h want zero",
                         {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata, reg_out);
    end
    @(posedge clk); #1;
    rst = 0;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL mid_first_cycle_ready got=%b want=000", {awready, wready, arready});
    end
    do_read(8'h04, 0, d, resp, ok, hok);
    checks++;
    if (!ok || d !== mdl_read(8'h04) || reg_out !== mdl_regout()) begin
      errors++; $display("FAIL mid_read4 ok=%0d data=%h reg_out=%h want %h %h", ok, d, reg_out, mdl_read(8'h04), mdl_regout());
    end
  endtask

  initial begin
    rst = 1;
    awaddr = '0; araddr = '0; awprot = 3'b0; arprot = 3'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    mdl_clear();
    test_reset();
    test_basic();
    test_split();
    test_bresp_hold();
    test_strobe();
    test_concurrent();
    test_back_to_back();
    test_alias();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/objectbuffer_s_axi_regs.md
Name: objectbuffer_s_axi_regs

Overview:
AXI4-Lite slave responder that provides the objectbuffer register bank: four 32-bit read/write registers at 0x00, 0x04, 0x08 and 0x0C.
It is the far end of the AXI4-Lite master VIP in the block-design bench. It accepts single-beat writes and reads, honours byte strobes, and exposes the register contents to the objectbuffer core logic.
Write and read channels are independent; each channel has one transaction outstanding at a time.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte-address width; must be 4 or greater.
ADDR_LSB, 2, log2 of the bytes per word; register index = ADDR[ADDR_LSB+1:ADDR_LSB].

Ports:
ACLK  in  1  single clock; all logic is rising-edge.
ARESET  in  1  asynchronous reset, active-high.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
REG_OUT  out  128  {reg3, reg2, reg1, reg0}; registered and live.

Behaviour:
Reset (ARESET=1, asynchronous):
- All registers = 0.
- AWREADY, WREADY, ARREADY, BVALID and RVALID = 0.
- BRESP, RRESP and RDATA = 0.
- Both FSMs go to IDLE.
- The ready outputs stay 0 for the first cycle after deassertion (registered "armed" flag), then rise.
- Reset asserted mid-transaction discards the transaction with no register update.

Write FSM, states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP:
- W_IDLE: AWREADY=1, WREADY=1.
  - AW and W handshake on the same edge -> commit write -> W_RESP.
  - AW only -> latch address -> W_WAIT_DATA.
  - W only -> latch data and strobe -> W_WAIT_ADDR.
- W_WAIT_DATA: AWREADY=0, WREADY=1. W handshake -> commit -> W_RESP.
- W_WAIT_ADDR: AWREADY=1, WREADY=0. AW handshake -> commit -> W_RESP.
- W_RESP: both readies 0, BVALID=1, BRESP=2'b00. BVALID, BRESP held until BREADY; handshake -> W_IDLE.
- Commit: for each byte b where WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA[8b+7:8b]. WSTRB=0 is accepted with no change and an OKAY response.
- BVALID rises on the edge of the final AW/W handshake, so it is visible the next cycle.
- Minimum write throughput: one write per 2 cycles (BREADY held high).

Read FSM, states R_IDLE, R_VALID:
- R_IDLE: ARREADY=1. AR handshake -> RDATA <= reg[idx], RRESP=2'b00 -> R_VALID.
- R_VALID: ARREADY=0, RVALID=1. RDATA and RRESP held stable until RREADY; handshake -> R_IDLE.
- Latency: RVALID is visible one cycle after the AR handshake. Minimum read throughput: one read per 2 cycles.

Address decode and channel interaction:
- ADDR[1:0] is ignored, so unaligned addresses round down.
- Bits above ADDR_LSB+1 alias onto the four registers unless the optional feature is enabled.
- Read and write are fully concurrent.
- If an AR handshake and a write commit hit the same register on the same edge, RDATA returns the pre-write value; REG_OUT shows the new value on the next cycle.

Optional Feature:
Macro: OBJBUF_SLVERR_EN.
- Defined: any address with a nonzero bit above ADDR_LSB+1 is out of range.
  - Writes to it: no register change, BRESP=2'b10 (SLVERR).
  - Reads from it: RDATA=0, RRESP=2'b10.
  - Handshake timing is unchanged.
- Undefined: addresses alias and every response is OKAY.

Test Plan:
1. Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> 0x1..0x4 with RRESP=0; REG_OUT=0x00000004_00000003_00000002_00000001.
2. AWVALID to 0x8 three cycles before WVALID=0xDEADBEEF; then separately WVALID three cycles before AWVALID to 0xC -> WREADY low in W_WAIT_ADDR; both registers updated; one BVALID per write.
3. Write 0x4 with BREADY held low 5 cycles -> BVALID held, BRESP=0, AWREADY/WREADY=0 throughout; back in W_IDLE the cycle after the BREADY handshake.
4. Write reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0010 -> reg0 reads 0xFFFF56FF.
5. Accept AW to 0x4 with 0xAA55AA55, assert ARESET before W -> all outputs 0; read 0x4 after reset -> 0x0; readies low on the first post-reset cycle.
6. With OBJBUF_SLVERR_EN and C_S_AXI_ADDR_WIDTH=8, write 0x99 to 0x10 -> BRESP=2'b10, all registers unchanged; read 0x10 -> RDATA=0, RRESP=2'b10. Without the macro, the same write lands in reg0 with OKAY.
